alu_op_sequencer: RTL and testbench

// Initiator-side sequencer for the 32-bit one-hot-controlled ALU. It accepts an

---
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator-side sequencer for a one-hot-strobed combinational ALU.
// Accepts a request over valid/ready, drives registered operands plus one strobe,
// waits SETTLE cycles, then captures result/flags, computes signed overflow and
// returns the response over valid/ready.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_add,
    output logic             alu_inc,
    output logic             alu_neg,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             rsp_v
);

    localparam int unsigned S = WIDTH - 1;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_req_ready;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_add;
    logic             r_inc;
    logic             r_neg;
    logic             r_sub;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_z;
    logic             r_rsp_n;
    logic             r_rsp_v;
    logic             w_v;

    // Signed overflow of the operation currently strobed, from held operands and live ALU result
    always_comb begin
        w_v = 1'b0;
        if (r_add) begin
            w_v = (r_alu_a[S] == r_alu_b[S]) && (alu_out[S] != r_alu_a[S]);
        end else if (r_sub) begin
            w_v = (r_alu_a[S] != r_alu_b[S]) && (alu_out[S] != r_alu_b[S]);
        end else if (r_neg) begin
            w_v = (r_alu_a == MIN_NEG);
        end else if (r_inc) begin
            w_v = (r_alu_b == MAX_POS);
        end
    end

    // Request/settle/response state machine with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_add       <= 1'b0;
            r_inc       <= 1'b0;
            r_neg       <= 1'b0;
            r_sub       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_z     <= 1'b0;
            r_rsp_n     <= 1'b0;
            r_rsp_v     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_alu_a     <= req_a;
                        r_alu_b     <= req_b;
                        r_add       <= (req_op == 2'b00);
                        r_inc       <= (req_op == 2'b01);
                        r_neg       <= (req_op == 2'b10);
                        r_sub       <= (req_op == 2'b11);
                        r_cnt       <= CNT_LOAD;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_z     <= alu_z;
                        r_rsp_n     <= alu_n;
                        r_rsp_v     <= w_v;
                        r_add       <= 1'b0;
                        r_inc       <= 1'b0;
                        r_neg       <= 1'b0;
                        r_sub       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_add       <= 1'b0;
                    r_inc       <= 1'b0;
                    r_neg       <= 1'b0;
                    r_sub       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_add   = r_add;
    assign alu_inc   = r_inc;
    assign alu_neg   = r_neg;
    assign alu_sub   = r_sub;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_z     = r_rsp_z;
    assign rsp_n     = r_rsp_n;
    assign rsp_v     = r_rsp_v;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (SETTLE=1 and SETTLE=3) each
// driving a behavioural ALU, checked against a signed-arithmetic reference model.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_op    [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic [31:0] alu_a     [2];
    logic [31:0] alu_b     [2];
    logic        alu_add   [2];
    logic        alu_inc   [2];
    logic        alu_neg   [2];
    logic        alu_sub   [2];
    logic [31:0] alu_out   [2];
    logic        alu_z     [2];
    logic        alu_n     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_z     [2];
    logic        rsp_n     [2];
    logic        rsp_v     [2];

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural one-hot ALU attached to each sequencer
    for (genvar k = 0; k < 2; k++) begin : g_alu
        assign alu_out[k] = alu_add[k] ? alu_a[k] + alu_b[k] :
                            alu_inc[k] ? alu_b[k] + 32'd1 :
                            alu_neg[k] ? 32'd0 - alu_a[k] :
                            alu_sub[k] ? alu_b[k] - alu_a[k] : 32'd0;
        assign alu_z[k] = (alu_out[k] == 32'd0);
        assign alu_n[k] = alu_out[k][31];
    end

    alu_op_sequencer #(.WIDTH(32), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_add(alu_add[0]), .alu_inc(alu_inc[0]), .alu_neg(alu_neg[0]), .alu_sub(alu_sub[0]),
        .alu_out(alu_out[0]), .alu_z(alu_z[0]), .alu_n(alu_n[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_z(rsp_z[0]), .rsp_n(rsp_n[0]), .rsp_v(rsp_v[0])
    );

    alu_op_sequencer #(.WIDTH(32), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_add(alu_add[1]), .alu_inc(alu_inc[1]), .alu_neg(alu_neg[1]), .alu_sub(alu_sub[1]),
        .alu_out(alu_out[1]), .alu_z(alu_z[1]), .alu_n(alu_n[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_z(rsp_z[1]), .rsp_n(rsp_n[1]), .rsp_v(rsp_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] strobes(input int s);
        return {28'd0, alu_sub[s], alu_neg[s], alu_inc[s], alu_add[s]};
    endfunction

    // Reference: result modulo 2^32; overflow when the exact signed result leaves int32 range
    task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic v);
        longint sa, sb, exact;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00:   exact = sa + sb;
            2'b01:   exact = sb + 1;
            2'b10:   exact = -sa;
            default: exact = sb - sa;
        endcase
        res = exact[31:0];
        v   = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    endtask

    task automatic txn(input int s, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit pester);
        int n;
        int lat;
        logic [31:0] er;
        logic ev;
        n = 0;
        @(negedge clk);
        while (!req_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", {31'd0, req_ready[s]}, 32'd1);
        req_valid[s] = 1'b1;
        req_op[s] = op;
        req_a[s] = a;
        req_b[s] = b;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        req_a[s] = $urandom;
        req_b[s] = $urandom;
        check("alu_a_latched", alu_a[s], a);
        check("alu_b_latched", alu_b[s], b);
        check("req_ready_busy", {31'd0, req_ready[s]}, 32'd0);
        lat = 0;
        while (!rsp_valid[s] && lat < 40) begin
            check("strobe_onehot", strobes(s), 32'd1 << op);
            rsp_ready[s] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        rsp_ready[s] = 1'b0;
        check("latency", lat, settle_of(s));
        check("strobes_off", strobes(s), 32'd0);
        ref_model(op, a, b, er, ev);
        check("rsp_data", rsp_data[s], er);
        check("rsp_z", {31'd0, rsp_z[s]}, {31'd0, er == 32'd0});
        check("rsp_n", {31'd0, rsp_n[s]}, {31'd0, er[31]});
        check("rsp_v", {31'd0, rsp_v[s]}, {31'd0, ev});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (pester) begin
                req_valid[s] = 1'b1;
                req_op[s] = 2'($urandom);
            end
            @(posedge clk);
            #1;
            req_valid[s] = 1'b0;
            check("bp_rsp_valid", {31'd0, rsp_valid[s]}, 32'd1);
            check("bp_rsp_data", rsp_data[s], er);
            check("bp_rsp_v", {31'd0, rsp_v[s]}, {31'd0, ev});
            check("bp_req_ready", {31'd0, req_ready[s]}, 32'd0);
            check("bp_alu_a", alu_a[s], a);
            check("bp_strobes", strobes(s), 32'd0);
        end
        @(negedge clk);
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[s] = 1'b0;
        check("hs_rsp_valid", {31'd0, rsp_valid[s]}, 32'd0);
        check("hs_req_ready", {31'd0, req_ready[s]}, 32'd1);
        check("hs_rsp_data_kept", rsp_data[s], er);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1;
            req_valid[s] = 1'b0;
            req_op[s] = 2'b00;
            req_a[s] = '0;
            req_b[s] = '0;
            rsp_ready[s] = 1'b0;
        end
        #12;
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", {31'd0, req_ready[s]}, 32'd1);
            check("rst_rsp_valid", {31'd0, rsp_valid[s]}, 32'd0);
            check("rst_strobes", strobes(s), 32'd0);
            check("rst_alu_a", alu_a[s], 32'd0);
            check("rst_alu_b", alu_b[s], 32'd0);
            check("rst_rsp_data", rsp_data[s], 32'd0);
            check("rst_rsp_flags", {29'd0, rsp_z[s], rsp_n[s], rsp_v[s]}, 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Directed corner cases on the SETTLE=1 instance
        txn(0, 2'b00, 32'd7, 32'd5, 0, 1'b0);
        txn(0, 2'b11, 32'd5, 32'd5, 1, 1'b0);
        txn(0, 2'b11, 32'h0000_0001, 32'h8000_0000, 0, 1'b0);
        txn(0, 2'b10, 32'h8000_0000, 32'd0, 2, 1'b1);
        txn(0, 2'b01, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        txn(0, 2'b01, 32'd0, 32'h7FFF_FFFF, 0, 1'b0);

        // Backpressure with dropped requests on the SETTLE=3 instance
        txn(1, 2'b00, 32'h7FFF_FFFF, 32'd1, 4, 1'b1);

        for (int i = 0; i < 30; i++) begin
            txn(i % 2, 2'($urandom), pick_operand(), pick_operand(),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while an ADD is in flight on the SETTLE=3 instance
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_op[1] = 2'b00;
        req_a[1] = 32'd3;
        req_b[1] = 32'd4;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("mid_add_strobe", strobes(1), 32'd1);
        #2;
        rst[1] = 1'b1;
        #1;
        check("arst_strobes", strobes(1), 32'd0);
        check("arst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready[1]}, 32'd1);
        @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_rsp", {31'd0, rsp_valid[1]}, 32'd0);
            check("post_rst_idle", {31'd0, req_ready[1]}, 32'd1);
        end
        txn(1, 2'b11, 32'd9, 32'd2, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
